regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter RWIDTH, default 6, which sets the register address width (2**RWIDTH entries).
REQ-002 The block SHALL have parameter DWIDTH, default 32, which sets the data width; it SHALL be a multiple of 8.
REQ-003 The block SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding and 0 means reads see registered state only.
REQ-004 The block SHALL have the following ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ra1, ra2  in  RWIDTH  read addresses.
- rd1, rd2  out  DWIDTH  read data.
- wa1, wa2  in  RWIDTH  write addresses.
- wd1, wd2  in  DWIDTH  write data.
- we1, we2  in  1  write enables.
- be1, be2  in  DWIDTH/8  byte enables; bit k qualifies byte k.
- clr  in  1  request a sequential clear of all registers.
- busy  out  1  high while the clear sweep runs.
- clr_done  out  1  one-cycle pulse when the sweep completes.

Function
REQ-005 Register 0 SHALL always read 0, and writes to it SHALL be discarded on both ports.
REQ-006 A write SHALL update only the bytes with be bit 1, at the rising edge where we=1 and busy=0.
REQ-007 If wa1==wa2 with both enabled, each byte SHALL take wd2 where be2 is set, else wd1 where be1 is set, else keep its old value.
REQ-008 Reads SHALL be combinational, with zero-cycle latency from ra to rd.
REQ-009 With BYPASS=1 and busy=0, rd SHALL return the stored value merged with same-cycle write bytes, using the REQ-007 priority.
REQ-010 With BYPASS=0, rd SHALL return the stored value only; the write becomes visible the cycle after.
REQ-011 The FSM SHALL have two states: IDLE and CLEAR.
REQ-012 In IDLE, clr=1 SHALL move the FSM to CLEAR on the next edge, load the sweep pointer with 1, and assert busy.
REQ-013 In CLEAR, each cycle SHALL zero the register at the pointer and increment the pointer.
REQ-014 When the pointer equals 2**RWIDTH-1, the FSM SHALL zero that register, return to IDLE, and pulse clr_done for exactly one cycle.
REQ-015 The sweep SHALL therefore last exactly 2**RWIDTH-1 cycles: busy is high for 63 cycles at the default width.
REQ-016 While busy=1, all writes SHALL be dropped, rd1/rd2 SHALL be 0, and further clr SHALL be ignored.
REQ-017 A clr arriving in the same cycle that clr_done pulses SHALL be ignored; a new request needs clr high again in IDLE.
REQ-018 The pointer SHALL never wrap to 0 within a sweep.

Reset
REQ-019 Asserting rst SHALL asynchronously zero all registers, put the FSM in IDLE, clear the pointer to 0, and drive busy=0 and clr_done=0.
REQ-020 A reset mid-sweep SHALL abort the sweep with no clr_done pulse.
REQ-021 The first write SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-022 Package regfile_pkg SHALL hold the state enum (IDLE, CLEAR) and the parameter defaults.
REQ-023 Byte-merge and forwarding logic SHALL be a sub-module, regfile_bypass_mux, instantiated once per read port.
REQ-024 Register storage SHALL be flops with asynchronous reset, not an inferred RAM.

Verification
REQ-025 Reset then basic write/read: rst pulse, then write wa1=5 wd1=32'hDEADBEEF be1=4'hF; the next cycle, ra1=5 -> rd1=32'hDEADBEEF, and ra2=0 -> rd2=0.
REQ-026 Port conflict: with reg 7 = 32'h11223344, drive wa1=wa2=7, wd1=32'hAAAAAAAA be1=4'hF, wd2=32'h55555555 be2=4'h3 -> reg 7 = 32'hAAAA5555.
REQ-027 Bypass: BYPASS=1, ra1=wa1=9, wd1=32'h000000FF be1=4'h1 over old value 32'h12345678 -> same-cycle rd1=32'h123456FF; with BYPASS=0, rd1=32'h12345678 that cycle.
REQ-028 Clear sweep: fill regs 1..63 with nonzero data, pulse clr -> busy high for 63 cycles, a single clr_done pulse, all registers read 0 afterwards, and a write issued during busy is lost.
REQ-029 Reset mid-sweep: assert rst 20 cycles into a sweep -> busy=0 immediately, no clr_done pulse, all registers 0.
REQ-030 Register 0 protection: we1=1 wa1=0 wd1=32'hFFFFFFFF -> rd at address 0 stays 0, including the same-cycle bypass path.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and parameter defaults for the multi-port register file.
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   localparam int unsigned RWIDTH_DEF = 6;
   localparam int unsigned DWIDTH_DEF = 32;
   localparam int unsigned BYPASS_DEF = 1;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Read-port data path: stored word merged with same-cycle write bytes, forced to 0 while busy.
module regfile_bypass_mux
   import regfile_pkg::*;
#(
   parameter int unsigned RWIDTH = RWIDTH_DEF,
   parameter int unsigned DWIDTH = DWIDTH_DEF,
   parameter int unsigned BYPASS = BYPASS_DEF
) (
   input  logic [RWIDTH-1:0]   ra_i,
   input  logic [DWIDTH-1:0]   stored_i,
   input  logic                wen1_i,
   input  logic [RWIDTH-1:0]   wa1_i,
   input  logic [DWIDTH-1:0]   wd1_i,
   input  logic [DWIDTH/8-1:0] be1_i,
   input  logic                wen2_i,
   input  logic [RWIDTH-1:0]   wa2_i,
   input  logic [DWIDTH-1:0]   wd2_i,
   input  logic [DWIDTH/8-1:0] be2_i,
   input  logic                busy_i,
   output logic [DWIDTH-1:0]   rd_o
);

   localparam int unsigned NB = DWIDTH / 8;

   always_comb begin
      rd_o = stored_i;
      if (BYPASS != 0) begin
         // Port 2 wins per byte, matching the storage write priority.
         for (int unsigned b = 0; b < NB; b++) begin
            if (wen2_i && (wa2_i == ra_i) && be2_i[b])
               rd_o[8*b +: 8] = wd2_i[8*b +: 8];
            else if (wen1_i && (wa1_i == ra_i) && be1_i[b])
               rd_o[8*b +: 8] = wd1_i[8*b +: 8];
         end
      end
      if (busy_i)
         rd_o = '0;
   end

endmodule

// File: rtl/regfile_mp.sv
// Two-read/two-write register file with byte enables, optional forwarding and a sequential clear sweep.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned RWIDTH = RWIDTH_DEF,
   parameter int unsigned DWIDTH = DWIDTH_DEF,
   parameter int unsigned BYPASS = BYPASS_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [RWIDTH-1:0]   ra1,
   input  logic [RWIDTH-1:0]   ra2,
   output logic [DWIDTH-1:0]   rd1,
   output logic [DWIDTH-1:0]   rd2,
   input  logic [RWIDTH-1:0]   wa1,
   input  logic [RWIDTH-1:0]   wa2,
   input  logic [DWIDTH-1:0]   wd1,
   input  logic [DWIDTH-1:0]   wd2,
   input  logic                we1,
   input  logic                we2,
   input  logic [DWIDTH/8-1:0] be1,
   input  logic [DWIDTH/8-1:0] be2,
   input  logic                clr,
   output logic                busy,
   output logic                clr_done
);

   localparam int unsigned NREG = 1 << RWIDTH;
   localparam int unsigned NB   = DWIDTH / 8;

   state_e              state_q, state_d;
   logic [RWIDTH-1:0]   ptr_q, ptr_d;
   logic                done_q, done_d;
   logic [DWIDTH-1:0]   regs_q [NREG];
   logic [DWIDTH-1:0]   regs_d [NREG];
   logic                wen1, wen2;

   assign busy     = (state_q == CLEAR);
   assign clr_done = done_q;
   // Writes to register 0 are filtered here so forwarding never exposes them either.
   assign wen1     = we1 && !busy && (wa1 != '0);
   assign wen2     = we2 && !busy && (wa2 != '0);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // A request coinciding with the completion pulse is dropped.
            if (clr && !done_q) begin
               state_d = CLEAR;
               ptr_d   = RWIDTH'(1);
            end
         end
         CLEAR: begin
            if (ptr_q == '1) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      regs_d = regs_q;
      for (int unsigned i = 1; i < NREG; i++) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (wen2 && (wa2 == RWIDTH'(i)) && be2[b])
               regs_d[i][8*b +: 8] = wd2[8*b +: 8];
            else if (wen1 && (wa1 == RWIDTH'(i)) && be1[b])
               regs_d[i][8*b +: 8] = wd1[8*b +: 8];
         end
      end
      if (busy)
         regs_d[ptr_q] = '0;
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         done_q  <= 1'b0;
         for (int unsigned i = 0; i < NREG; i++)
            regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
         for (int unsigned i = 0; i < NREG; i++)
            regs_q[i] <= regs_d[i];
      end
   end

   regfile_bypass_mux #(.RWIDTH(RWIDTH), .DWIDTH(DWIDTH), .BYPASS(BYPASS)) u_rd1 (
      .ra_i(ra1), .stored_i(regs_q[ra1]),
      .wen1_i(wen1), .wa1_i(wa1), .wd1_i(wd1), .be1_i(be1),
      .wen2_i(wen2), .wa2_i(wa2), .wd2_i(wd2), .be2_i(be2),
      .busy_i(busy), .rd_o(rd1)
   );

   regfile_bypass_mux #(.RWIDTH(RWIDTH), .DWIDTH(DWIDTH), .BYPASS(BYPASS)) u_rd2 (
      .ra_i(ra2), .stored_i(regs_q[ra2]),
      .wen1_i(wen1), .wa1_i(wa1), .wd1_i(wd1), .be1_i(be1),
      .wen2_i(wen2), .wa2_i(wa2), .wd2_i(wd2), .be2_i(be2),
      .busy_i(busy), .rd_o(rd2)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one forwarding instance and one registered-only instance share stimulus.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  ra1, ra2, wa1, wa2;
   logic [31:0] wd1, wd2;
   logic        we1, we2, clr;
   logic [3:0]  be1, be2;
   logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic        busy_b, done_b, busy_n, done_n;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_mp #(.RWIDTH(6), .DWIDTH(32), .BYPASS(1)) u_byp (
      .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
      .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2), .we1(we1), .we2(we2),
      .be1(be1), .be2(be2), .clr(clr), .busy(busy_b), .clr_done(done_b)
   );

   regfile_mp #(.RWIDTH(6), .DWIDTH(32), .BYPASS(0)) u_nob (
      .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
      .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2), .we1(we1), .we2(we2),
      .be1(be1), .be2(be2), .clr(clr), .busy(busy_n), .clr_done(done_n)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      we1 = 1'b0; we2 = 1'b0; be1 = 4'h0; be2 = 4'h0;
      wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0; clr = 1'b0;
   endtask

   task automatic write1(input logic [5:0] a, input logic [31:0] d);
      @(negedge clk);
      idle_inputs();
      we1 = 1'b1; wa1 = a; wd1 = d; be1 = 4'hF;
   endtask

   int busy_cnt, done_cnt, cyc;
   logic done_seen;

   initial begin
      idle_inputs();
      ra1 = '0; ra2 = '0;
      rst = 1'b1;

      // Reset state
      @(negedge clk);
      #1;
      chk("rst_rd1", rd1_b, 32'h0);
      chk("rst_busy", {31'b0, busy_b}, 32'h0);
      chk("rst_done", {31'b0, done_b}, 32'h0);

      // First write accepted at first edge after reset release; same-cycle forwarding
      @(negedge clk);
      rst = 1'b0;
      we1 = 1'b1; wa1 = 6'd5; wd1 = 32'hDEADBEEF; be1 = 4'hF; ra1 = 6'd5;
      #1;
      chk("fwd_first_byp", rd1_b, 32'hDEADBEEF);
      chk("fwd_first_nob", rd1_n, 32'h0);
      @(negedge clk);
      idle_inputs();
      ra1 = 6'd5; ra2 = 6'd0;
      #1;
      chk("basic_rd1_byp", rd1_b, 32'hDEADBEEF);
      chk("basic_rd1_nob", rd1_n, 32'hDEADBEEF);
      chk("basic_rd2_r0", rd2_b, 32'h0);

      // Port conflict on reg 7
      write1(6'd7, 32'h11223344);
      @(negedge clk);
      idle_inputs();
      we1 = 1'b1; wa1 = 6'd7; wd1 = 32'hAAAAAAAA; be1 = 4'hF;
      we2 = 1'b1; wa2 = 6'd7; wd2 = 32'h55555555; be2 = 4'h3;
      ra1 = 6'd7;
      #1;
      chk("conf_fwd_byp", rd1_b, 32'hAAAA5555);
      chk("conf_fwd_nob", rd1_n, 32'h11223344);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("conf_store_byp", rd1_b, 32'hAAAA5555);
      chk("conf_store_nob", rd1_n, 32'hAAAA5555);

      // Sparse byte enables on both ports: unenabled bytes keep old value
      @(negedge clk);
      we1 = 1'b1; wa1 = 6'd7; wd1 = 32'h11111111; be1 = 4'b0100;
      we2 = 1'b1; wa2 = 6'd7; wd2 = 32'h22222222; be2 = 4'b0001;
      @(negedge clk);
      idle_inputs();
      #1;
      chk("sparse_be", rd1_n, 32'hAA115522);

      // Bypass vs registered-only
      write1(6'd9, 32'h12345678);
      @(negedge clk);
      idle_inputs();
      we1 = 1'b1; wa1 = 6'd9; wd1 = 32'h000000FF; be1 = 4'h1; ra1 = 6'd9;
      #1;
      chk("byp_same_cyc", rd1_b, 32'h123456FF);
      chk("nob_same_cyc", rd1_n, 32'h12345678);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("nob_next_cyc", rd1_n, 32'h123456FF);

      // Register 0 protection on both ports, including forwarding
      @(negedge clk);
      we1 = 1'b1; wa1 = 6'd0; wd1 = 32'hFFFFFFFF; be1 = 4'hF;
      we2 = 1'b1; wa2 = 6'd0; wd2 = 32'hFFFFFFFF; be2 = 4'hF;
      ra1 = 6'd0; ra2 = 6'd0;
      #1;
      chk("r0_fwd_rd1", rd1_b, 32'h0);
      chk("r0_fwd_rd2", rd2_b, 32'h0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("r0_store_byp", rd1_b, 32'h0);
      chk("r0_store_nob", rd2_n, 32'h0);

      // Fill 1..63, two writes per cycle where possible
      for (int a = 1; a < 64; a += 2) begin
         @(negedge clk);
         idle_inputs();
         we1 = 1'b1; wa1 = 6'(a); wd1 = 32'hA5000000 | 32'(a); be1 = 4'hF;
         if (a + 1 < 64) begin
            we2 = 1'b1; wa2 = 6'(a + 1); wd2 = 32'hA5000000 | 32'(a + 1); be2 = 4'hF;
         end
      end
      @(negedge clk);
      idle_inputs();
      ra1 = 6'd33; ra2 = 6'd63;
      #1;
      chk("fill_r33", rd1_n, 32'hA5000021);
      chk("fill_r63", rd2_n, 32'hA500003F);

      // Clear sweep
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      we1 = 1'b1; wa1 = 6'd3; wd1 = 32'hCAFEF00D; be1 = 4'hF; ra1 = 6'd3;
      #1;
      chk("busy_rd_zero", rd1_b, 32'h0);
      chk("busy_rd_zero_nob", rd1_n, 32'h0);
      busy_cnt  = 1;
      done_cnt  = 0;
      done_seen = 1'b0;
      cyc = 0;
      while (!done_seen && cyc < 200) begin
         @(negedge clk);
         idle_inputs();
         if (cyc < 5) clr = 1'b1;
         cyc++;
         if (busy_b) busy_cnt++;
         if (done_b) begin
            done_cnt++;
            done_seen = 1'b1;
            clr = 1'b1;
         end
      end
      chk("sweep_bounded", {31'b0, done_seen}, 32'h1);
      chk("sweep_busy_cycles", 32'(busy_cnt), 32'd63);
      @(negedge clk);
      clr = 1'b0;
      if (done_b) done_cnt++;
      #1;
      chk("done_clr_ignored", {31'b0, busy_b}, 32'h0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (done_b) done_cnt++;
      end
      chk("sweep_done_pulses", 32'(done_cnt), 32'd1);
      chk("sweep_busy_after", {31'b0, busy_n}, 32'h0);
      for (int a = 0; a < 64; a += 2) begin
         @(negedge clk);
         ra1 = 6'(a); ra2 = 6'(a + 1);
         #1;
         chk("swept_pair", rd1_n | rd2_n | rd1_b | rd2_b, 32'h0);
      end

      // Reset in the middle of a sweep
      write1(6'd10, 32'h0BADC0DE);
      write1(6'd50, 32'h87654321);
      @(negedge clk);
      idle_inputs();
      ra1 = 6'd50;
      #1;
      chk("prefill_r50", rd1_b, 32'h87654321);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done_b) done_cnt++;
      end
      chk("mid_busy", {31'b0, busy_b}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_busy", {31'b0, busy_b}, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done_b || done_n) done_cnt++;
      end
      rst = 1'b0;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         if (done_b || done_n) done_cnt++;
      end
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      ra1 = 6'd50; ra2 = 6'd10;
      #1;
      chk("abort_r50", rd1_n, 32'h0);
      chk("abort_r10", rd2_n, 32'h0);
      ra1 = 6'd9; ra2 = 6'd7;
      #1;
      chk("abort_r9_r7", rd1_b | rd2_b, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
